if_id_skid: RTL and testbench

Parametrised instruction-fetch/decode pipeline register with valid/ready handshaking and a two-entry skid buffer. It sits between the fetch unit and the decoder. It replaces the bare stall/flush register with full backpressure support, bubble tracking, and a NOP-filled output when empty or flushed. Latency is one cycle. Sustained throughput is one instruction per cycle.

---
 rtl/if_id_skid_pkg.sv | 27 ++
 rtl/if_id_skid_pipe_perf_cnt.sv | 31 +++
 rtl/if_id_skid.sv | 139 +++++++++++++
 tb/tb_if_id_skid.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_pkg.sv
//============================================================================
// Module  : if_id_skid_pkg
// Brief   : Shared constants, defaults and state encoding for the IF/ID skid stage.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package if_id_skid_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam int          DEF_ILEN      = 32;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;
    localparam logic RST_ACTIVE = 1'b1;

    // Encoding 2'd3 is unused and recovers to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage : if_id_skid_pkg

`default_nettype wire

// File: rtl/if_id_skid_pipe_perf_cnt.sv
//============================================================================
// Module  : pipe_perf_cnt
// Brief   : 32-bit wrapping event counter with synchronous clear.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module pipe_perf_cnt
    import if_id_skid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else if (inc_i == TRUE) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_perf_cnt

`default_nettype wire

// File: rtl/if_id_skid.sv
//============================================================================
// Module  : if_id_skid
// Brief   : IF/ID pipeline register with valid/ready handshake and a
//           two-entry (main + skid) buffer. Optional counters: IF_ID_SKID_PERF_EN.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter int              ILEN      = DEF_ILEN,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(DEF_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [ILEN-1:0] in_instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [ILEN-1:0] out_instr_o
`ifdef IF_ID_SKID_PERF_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    state_e          state_q,    state_d;
    logic [XLEN-1:0] m_pc_q,     m_pc_d;
    logic [ILEN-1:0] m_instr_q,  m_instr_d;
    logic [XLEN-1:0] s_pc_q,     s_pc_d;
    logic [ILEN-1:0] s_instr_q,  s_instr_d;

    logic m_valid;
    logic in_fire;
    logic out_fire;

    // Entry valid bits are decoded from the registered state, so in_ready has
    // no combinational dependence on out_ready.
    assign m_valid    = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign in_ready_o = (state_q != ST_TWO);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = m_valid & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q   <= ST_EMPTY;
            m_pc_q    <= '0;
            m_instr_q <= NOP_INSTR;
            s_pc_q    <= '0;
            s_instr_q <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            m_pc_q    <= m_pc_d;
            m_instr_q <= m_instr_d;
            s_pc_q    <= s_pc_d;
            s_instr_q <= s_instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;

        if (flush_i == TRUE) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_pc_d    = in_pc_i;
                        m_instr_d = in_instr_i;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_pc_d    = in_pc_i;
                        m_instr_d = in_instr_i;
                    end else if (in_fire) begin
                        s_pc_d    = in_pc_i;
                        s_instr_d = in_instr_i;
                        state_d   = ST_TWO;
                    end else if (out_fire) begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        m_pc_d    = s_pc_q;
                        m_instr_d = s_instr_q;
                        state_d   = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid_o = m_valid;
    assign out_pc_o    = m_valid ? m_pc_q    : '0;
    assign out_instr_o = m_valid ? m_instr_q : NOP_INSTR;

`ifdef IF_ID_SKID_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = m_valid & ~out_ready_i;
    assign flush_evt = flush_i & (state_q != ST_EMPTY);

    pipe_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    pipe_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_evt),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule : if_id_skid

`default_nettype wire

// File: tb/tb_if_id_skid.sv
//============================================================================
// Module  : tb_if_id_skid
// Brief   : Directed scoreboard bench for if_id_skid.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_ID_SKID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] stall_m;
    logic [31:0] flush_m;
`endif

    beat_t q[$];
    int    n_cmp;
    int    n_err;

    if_id_skid dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_pc_i     (in_pc),
        .in_instr_i  (in_instr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pc_o    (out_pc),
        .out_instr_o (out_instr)
`ifdef IF_ID_SKID_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = 32'hA500_0000 ^ pc;
    endtask

    // Check outputs against the queue model at the falling edge, then advance
    // the model by what the coming rising edge should do.
    task automatic tick();
        logic  in_fire_m;
        logic  out_fire_m;
        beat_t b;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
        chk("out_pc",    out_pc,    (q.size() > 0) ? q[0].pc    : 32'd0);
        chk("out_instr", out_instr, (q.size() > 0) ? q[0].instr : NOP);
`ifdef IF_ID_SKID_PERF_EN
        chk("stall_cnt", stall_cnt, stall_m);
        chk("flush_cnt", flush_cnt, flush_m);
`endif
        in_fire_m  = in_valid && (q.size() < 2);
        out_fire_m = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
`ifdef IF_ID_SKID_PERF_EN
            stall_m = '0;
            flush_m = '0;
`endif
        end else begin
`ifdef IF_ID_SKID_PERF_EN
            if ((q.size() > 0) && !out_ready) stall_m = stall_m + 32'd1;
            if (flush && (q.size() > 0))      flush_m = flush_m + 32'd1;
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (out_fire_m) void'(q.pop_front());
                if (in_fire_m) begin
                    b.pc    = in_pc;
                    b.instr = in_instr;
                    q.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef IF_ID_SKID_PERF_EN
        stall_m = '0;
        flush_m = '0;
`endif
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h500);
        @(posedge clk);
        #1;
        // Reset held with in_valid asserted
        tick();
        tick();
        rst = 1'b0;

        // Streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h100); tick();
        drive(1'b1, 32'h104); tick();
        drive(1'b1, 32'h108); tick();
        drive(1'b0, 32'h0);   tick();
        tick();

        // Backpressure: fill M and S, hold third beat at fetch
        out_ready = 1'b0;
        drive(1'b1, 32'h100); tick();
        drive(1'b1, 32'h104); tick();
        drive(1'b1, 32'h108); tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        drive(1'b0, 32'h0);
        tick();
        tick();
        tick();

        // Flush in TWO with a simultaneous incoming beat
        out_ready = 1'b0;
        drive(1'b1, 32'h200); tick();
        drive(1'b1, 32'h204); tick();
        flush = 1'b1;
        drive(1'b1, 32'h208); tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);   tick();
        flush = 1'b1;         tick();
        flush = 1'b0;         tick();

        // Simultaneous accept and consume in ONE
        drive(1'b1, 32'h300); tick();
        out_ready = 1'b1;
        drive(1'b1, 32'h304); tick();
        drive(1'b0, 32'h0);   tick();
        tick();

        // Reset while both entries are held
        out_ready = 1'b0;
        drive(1'b1, 32'h400); tick();
        drive(1'b1, 32'h404); tick();
        drive(1'b0, 32'h0);
        rst = 1'b1;           tick();
        rst = 1'b0;           tick();
        out_ready = 1'b1;     tick();

`ifdef IF_ID_SKID_PERF_EN
        // Stall counter wrap
        out_ready = 1'b0;
        drive(1'b1, 32'h600); tick();
        drive(1'b0, 32'h0);
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.cnt_q;
        stall_m = 32'hFFFF_FFFF;
        tick();
        out_ready = 1'b1;
        tick();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_if_id_skid

`default_nettype wire
